router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet source for the router input port. It buffers one packet's payload, then transmits header, payload and parity bytes under the router's pkt_valid/busy protocol.
- It sits between a test or host data supplier and the router top. It is the write-side counterpart to the router FIFO/read path.
- Packet format: header = {pay_len[5:0], dest_addr[1:0]}, then pay_len payload bytes, then parity = XOR of the header and all payload bytes.

Parameters:
- MAX_LEN, 63: maximum payload length in bytes; sets the internal buffer depth.
- BAD_ADDR, 2'd3: destination address the router rejects.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to build a packet; sampled only in IDLE.
- dest_addr  input  2  destination port; captured with start.
- pay_len  input  6  payload length; captured with start.
- pl_data  input  8  payload byte from the supplier.
- pl_valid  input  1  pl_data is valid.
- pl_ready  output  1  block accepts pl_data this cycle.
- busy  input  1  router stall; while high the current byte must be held.
- data_out  output  8  byte to the router data input.
- pkt_valid  output  1  high during header and payload bytes, low during the parity byte.
- active  output  1  high from start acceptance until DONE completes.
- done  output  1  one-cycle pulse after the parity byte is accepted.
- err  output  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset: all outputs are 0; state is IDLE; index, length, address and parity registers are 0. Buffer contents are don't-care. Reset in any state aborts the packet with no done pulse and takes effect on the next edge.
- All outputs are registered (Moore). A beat is accepted on any edge where the state is HEADER, PAYLOAD or PARITY and busy=0.
- IDLE:
  - start=1 with pay_len=0 or dest_addr=BAD_ADDR: err=1 for one cycle; stay in IDLE.
  - start=1 otherwise: capture dest_addr and pay_len; parity<={pay_len,dest_addr}; idx<=0; active<=1; pl_ready<=1; go to LOAD.
- LOAD: on each edge with pl_valid and pl_ready both high:
  - buf[idx]<=pl_data; parity^=pl_data; idx++.
  - When the final byte is taken (idx==len-1): pl_ready<=0; idx<=0; go to HEADER with data_out=header and pkt_valid=1.
  - pl_valid low means the block waits; there is no timeout.
- HEADER: on an accepted beat, data_out<=buf[0] and go to PAYLOAD. While busy=1, data_out and pkt_valid hold.
- PAYLOAD: on an accepted beat:
  - If idx<len-1: idx++ and data_out<=buf[idx+1].
  - If idx==len-1: data_out<=parity; pkt_valid<=0; go to PARITY.
- PARITY: on an accepted beat, data_out<=0, done<=1 and go to DONE.
- DONE: done<=0; active<=0; go to IDLE. A start in this cycle is ignored; a new start is accepted from the IDLE cycle after.
- start outside IDLE is ignored, with no err pulse.
- Latency with pl_valid held high and busy=0: start edge, then len LOAD cycles, then header, len payload bytes, parity, done.
- pkt_valid never drops inside a packet. busy may assert on any beat, including the header and parity, and may stay high indefinitely.
- len=1: the single payload byte is followed directly by parity. len=63: idx reaches 62 without overflow.
- Parity and index arithmetic is fixed width (8-bit XOR, 6-bit index) with no wrap in legal operation.

Test Plan:
- Basic packet: rst pulse, then start with addr=1, len=3, payload 0x11,0x22,0x33, busy=0. Required byte sequence: header 0x0D (pkt_valid=1), then 0x11, 0x22, 0x33 (pkt_valid=1), then parity 0x0D (pkt_valid=0). done pulses once; active then drops.
- Busy stall: same packet with busy=1 for 3 cycles during byte 0x22. data_out stays 0x22 and pkt_valid stays 1 for 4 cycles; the remaining sequence is unchanged.
- Rejects: start with addr=3, len=5, then start with addr=0, len=0. err pulses once for each; active stays 0; no pkt_valid.
- Supplier gaps: len=4 with pl_valid toggling every other cycle. All 4 bytes are buffered correctly; header appears only after the 4th byte; the transmitted parity equals XOR of the header and payload.
- Max length: addr=2, len=63 with random payload. 65 bytes are transmitted; pkt_valid is high for exactly 64 of them; parity matches the scoreboard.
- Mid-packet reset: rst=1 during PAYLOAD. The next cycle shows data_out=0, pkt_valid=0, active=0, no done. A following packet transmits correctly.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one packet payload, then sends header, payload and parity under pkt_valid/busy
module router_pkt_tx #(
  parameter int         MAX_LEN  = 63,
  parameter logic [1:0] BAD_ADDR = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       active,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE} state_t;
  state_t     state_q;
  logic [5:0] idx_q, len_q;
  logic [1:0] addr_q;
  logic [7:0] par_q, data_out_q;
  logic       pl_ready_q, pkt_valid_q, active_q, done_q, err_q;
  logic [7:0] mem_q [MAX_LEN];
  logic       take, last;
  assign take      = pl_valid && pl_ready_q;
  assign last      = idx_q == len_q - 6'd1;
  assign pl_ready  = pl_ready_q;
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign active    = active_q;
  assign done      = done_q;
  assign err       = err_q;
  // payload buffer needs no reset; only written while loading
  always_ff @(posedge clk)
    if (state_q == LOAD && take) mem_q[idx_q] <= pl_data;
  // packet FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      par_q       <= '0;
      data_out_q  <= '0;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            if (pay_len == 6'd0 || dest_addr == BAD_ADDR) err_q <= 1'b1;
            else begin
              len_q      <= pay_len;
              addr_q     <= dest_addr;
              par_q      <= {pay_len, dest_addr};
              idx_q      <= '0;
              active_q   <= 1'b1;
              pl_ready_q <= 1'b1;
              state_q    <= LOAD;
            end
          end
        LOAD:
          if (take) begin
            par_q <= par_q ^ pl_data;
            if (last) begin
              pl_ready_q  <= 1'b0;
              idx_q       <= '0;
              data_out_q  <= {len_q, addr_q};
              pkt_valid_q <= 1'b1;
              state_q     <= HEADER;
            end else idx_q <= idx_q + 6'd1;
          end
        HEADER:
          if (!busy) begin
            data_out_q <= mem_q[0];
            state_q    <= PAYLOAD;
          end
        PAYLOAD:
          if (!busy) begin
            if (last) begin
              data_out_q  <= par_q;
              pkt_valid_q <= 1'b0;
              state_q     <= PARITY;
            end else begin
              idx_q      <= idx_q + 6'd1;
              data_out_q <= mem_q[idx_q + 6'd1];
            end
          end
        PARITY:
          if (!busy) begin
            data_out_q <= '0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        DONE: begin
          done_q   <= 1'b0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized scoreboard bench for the packet transmitter
module tb_router_pkt_tx;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, pl_valid = 1'b0, busy = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
  logic [7:0] pl_data = '0;
  logic       pl_ready, pkt_valid, active, done, err;
  logic [7:0] data_out;

  router_pkt_tx dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .active(active), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic pv;} beat_t;
  beat_t      exp_q [$];
  logic [7:0] pay [64];
  int passed = 0, total = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, n22 = 0, beats = 0;
  int bmode = 0;
  bit in_pkt = 0, stalled = 0;

  task automatic check(input string n, input int a, input int e);
    total++;
    if (a != e) $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    else passed++;
  endtask

  always @(posedge clk) cyc++;

  // busy generator: off, random, or one 3-cycle stall on byte 0x22
  always begin
    @(posedge clk);
    #1;
    if (bmode == 1) busy = ($urandom_range(0, 3) == 0);
    else if (bmode == 2 && !stalled && pkt_valid && data_out == 8'h22) begin
      busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 busy = 1'b0;
      stalled = 1;
    end else busy = 1'b0;
  end

  // monitor: compares presented bytes with the scoreboard, pops on accepted beats
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (pkt_valid && data_out == 8'h22) n22++;
    if (rst) in_pkt = 0;
    else if (pkt_valid || in_pkt) begin
      if (exp_q.size() == 0) check("unexpected_beat", int'(data_out), -1);
      else begin
        check("beat_data", int'(data_out), int'(exp_q[0].d));
        check("beat_pkt_valid", int'(pkt_valid), int'(exp_q[0].pv));
        if (!busy) begin
          void'(exp_q.pop_front());
          in_pkt = pkt_valid;
          beats++;
        end
      end
    end
  end

  // reference: header, payload, then XOR of everything before
  task automatic push_expected(input logic [1:0] a, input int n);
    logic [7:0] p;
    p = {n[5:0], a};
    exp_q.push_back('{d: p, pv: 1'b1});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{d: pay[k], pv: 1'b1});
      p = p ^ pay[k];
    end
    exp_q.push_back('{d: p, pv: 1'b0});
  endtask

  task automatic send_pkt(input logic [1:0] a, input int n, input bit gap, input bit abort);
    int d0 = done_cnt, e0 = err_cnt, b0 = beats, t0, i = 0, cb = 0, w = 0;
    bit ph = 1, take;
    push_expected(a, n);
    start = 1'b1; dest_addr = a; pay_len = n[5:0];
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    check("active_on", int'(active), 1);
    while (i < n && cb < 4000) begin
      pl_valid = gap ? ph : 1'b1;
      ph = ~ph;
      pl_data = pl_valid ? pay[i] : 8'($urandom);
      start = (cb == 2);
      dest_addr = 2'd3;
      @(negedge clk);
      take = pl_valid && pl_ready;
      @(posedge clk);
      #1;
      if (take) i++;
      cb++;
    end
    pl_valid = 1'b0; start = 1'b0;
    check("payload_taken", i, n);
    if (abort) begin
      while (exp_q.size() > n - 1 && w < 3000) begin @(negedge clk); w++; end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_data_out", int'(data_out), 0);
      check("rst_pkt_valid", int'(pkt_valid), 0);
      check("rst_active", int'(active), 0);
      check("rst_done", int'(done), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("rst_no_done", done_cnt - d0, 0);
      return;
    end
    while (done_cnt == d0 && w < 3000) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("active_off", int'(active), 0);
    check("no_err_in_pkt", err_cnt - e0, 0);
    check("beat_count", beats - b0, n + 2);
    check("queue_empty", exp_q.size(), 0);
    if (!gap && bmode == 0) check("latency", done_cyc - t0, 2 * n + 2);
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] n);
    start = 1'b1; dest_addr = a; pay_len = n;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("err_pulse", int'(err), 1);
    check("rej_active", int'(active), 0);
    check("rej_pkt_valid", int'(pkt_valid), 0);
    @(negedge clk);
    check("err_one_cycle", int'(err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_data_out", int'(data_out), 0);
    check("reset_pkt_valid", int'(pkt_valid), 0);
    check("reset_active", int'(active), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_pl_ready", int'(pl_ready), 0);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    n22 = 0;
    send_pkt(2'd1, 3, 0, 0);
    check("no_stall_22", n22, 1);
    bmode = 2; stalled = 0; n22 = 0;
    send_pkt(2'd1, 3, 0, 0);
    check("stall_22_cycles", n22, 4);
    bmode = 0;
    e0 = err_cnt;
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);
    check("err_count", err_cnt - e0, 2);
    for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
    send_pkt(2'd0, 4, 1, 0);
    for (int k = 0; k < 63; k++) pay[k] = 8'($urandom);
    send_pkt(2'd2, 63, 0, 0);
    bmode = 1;
    send_pkt(2'd2, 63, 1, 0);
    bmode = 0;
    for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
    send_pkt(2'd1, 8, 0, 1);
    send_pkt(2'd0, 5, 0, 0);
    send_pkt(2'd2, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 63);
      for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
      bmode = r[0];
      send_pkt(2'($urandom_range(0, 2)), n, r[1], 0);
    end
    bmode = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
